// File: rtl/antirrebote_entradas.sv
// antirrebote_entradas: multi-channel switch/button debouncer.
// Each channel is synchronized through two flops and then filtered by a
// per-channel counter. A new level is accepted only after it has been held
// for CICLOS_ESTABLES consecutive cycles.
// Optional feature macro: ANTIRREBOTE_FLANCOS_EN enables the registered
// edge outputs (flanco_subida, flanco_bajada, cambio). Without it those
// outputs are tied to 0 and no edge-detection registers exist.
module antirrebote_entradas #(
    parameter int ANCHO           = 3,
    parameter int CICLOS_ESTABLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ANCHO-1:0] entrada,
    output logic [ANCHO-1:0] estable,
    output logic [ANCHO-1:0] flanco_subida,
    output logic [ANCHO-1:0] flanco_bajada,
    output logic             cambio
);

    // A single-cycle filter still needs a 1-bit counter so the compare is legal.
    localparam int ANCHO_CONT = (CICLOS_ESTABLES > 1) ? $clog2(CICLOS_ESTABLES) : 1;
    localparam logic [ANCHO_CONT-1:0] CUENTA_MAX = ANCHO_CONT'(CICLOS_ESTABLES - 1);

    logic [ANCHO-1:0]      r_sinc1;
    logic [ANCHO-1:0]      r_sinc2;
    logic [ANCHO-1:0]      r_estable;
    logic [ANCHO_CONT-1:0] r_contador [ANCHO];
    logic [ANCHO-1:0]      w_acepta;

    // Two-flop synchronizer for the raw asynchronous inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sinc1 <= '0;
            r_sinc2 <= '0;
        end else begin
            r_sinc1 <= entrada;
            r_sinc2 <= r_sinc1;
        end
    end

    // A channel accepts its new level when it disagrees and the count is complete.
    always_comb begin
        w_acepta = '0;
        for (int i = 0; i < ANCHO; i++) begin
            w_acepta[i] = (r_sinc2[i] != r_estable[i]) && (r_contador[i] == CUENTA_MAX);
        end
    end

    // Per-channel hold counter; clears on agreement or acceptance, so it never wraps.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ANCHO; i++) begin
            if (reset) begin
                r_contador[i] <= '0;
            end else if (r_sinc2[i] == r_estable[i]) begin
                r_contador[i] <= '0;
            end else if (w_acepta[i]) begin
                r_contador[i] <= '0;
            end else begin
                r_contador[i] <= r_contador[i] + 1'b1;
            end
        end
    end

    // Debounced level flips on the cycle a channel accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estable <= '0;
        end else begin
            r_estable <= r_estable ^ w_acepta;
        end
    end

    assign estable = r_estable;

`ifdef ANTIRREBOTE_FLANCOS_EN
    logic [ANCHO-1:0] r_flancoSubida;
    logic [ANCHO-1:0] r_flancoBajada;
    logic             r_cambio;

    // Edge pulses registered alongside estable so they coincide with its new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flancoSubida <= '0;
            r_flancoBajada <= '0;
            r_cambio       <= 1'b0;
        end else begin
            r_flancoSubida <= w_acepta & ~r_estable;
            r_flancoBajada <= w_acepta & r_estable;
            r_cambio       <= |w_acepta;
        end
    end

    assign flanco_subida = r_flancoSubida;
    assign flanco_bajada = r_flancoBajada;
    assign cambio        = r_cambio;
`else
    assign flanco_subida = '0;
    assign flanco_bajada = '0;
    assign cambio        = 1'b0;
`endif

endmodule

// File: doc/antirrebote_entradas.md
ANTIRREBOTE_ENTRADAS -- requirements
Module: antirrebote_entradas

Interface
REQ-001 SHALL have parameter ANCHO, default 3: number of independent input channels (switches[2:0]).
REQ-002 SHALL have parameter CICLOS_ESTABLES, default 1000000: clk cycles an input must hold a new level before acceptance (20 ms at 50 MHz); legal range 1..2^24.
REQ-003 SHALL have port clk  input  1  free_50MHz system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port entrada  input  ANCHO  raw asynchronous switch/button levels.
REQ-006 SHALL have port estable  output  ANCHO  debounced level per channel, feeds FSM_inicar_proceso reset/boton inputs.
REQ-007 SHALL have port flanco_subida  output  ANCHO  one-cycle pulse when estable[i] goes 0->1.
REQ-008 SHALL have port flanco_bajada  output  ANCHO  one-cycle pulse when estable[i] goes 1->0.
REQ-009 SHALL have port cambio  output  1  OR of all flanco_subida and flanco_bajada bits, same cycle.

Function
REQ-010 SHALL pass each entrada bit through a two-flop synchronizer (sinc1, sinc2) before any other use.
REQ-011 SHALL keep per channel a counter of width clog2(CICLOS_ESTABLES), minimum 1 bit.
REQ-012 SHALL, per channel each cycle: if sinc2 == estable, clear counter; else if counter == CICLOS_ESTABLES-1, invert estable and clear counter; else increment counter.
REQ-013 SHALL give latency of exactly CICLOS_ESTABLES+2 clk edges from the first edge sampling a new held entrada level to estable changing.
REQ-014 SHALL discard any pulse or glitch on sinc2 shorter than CICLOS_ESTABLES cycles: counter clears on return to the estable level, estable unchanged.
REQ-015 SHALL never wrap the counter; it cannot exceed CICLOS_ESTABLES-1.
REQ-016 SHALL register flanco_subida/flanco_bajada so they are high in exactly the cycle estable shows its new value, and low otherwise.
REQ-017 SHALL handle channels fully independently; simultaneous acceptance on several channels asserts several flanco bits in the same cycle and a single cycle of cambio.
REQ-018 SHALL treat CICLOS_ESTABLES = 1 as pure synchronization: latency 3 edges, no filtering.

Reset
REQ-019 SHALL, while reset is high at a clk edge, clear sinc1, sinc2, all counters, estable, flanco_subida, flanco_bajada and cambio to 0.
REQ-020 SHALL abandon any in-progress count on reset; no flanco pulse is generated by reset itself.
REQ-021 SHALL, if entrada[i] is high when reset releases, raise estable[i] CICLOS_ESTABLES+2 edges after the first non-reset edge, with one flanco_subida[i] pulse.

Configuration
REQ-022 SHALL use macro ANTIRREBOTE_FLANCOS_EN: when defined, flanco_subida, flanco_bajada and cambio behave per REQ-016/017.
REQ-023 SHALL, when ANTIRREBOTE_FLANCOS_EN is undefined, tie flanco_subida, flanco_bajada and cambio to constant 0 with no edge-detection registers; estable behaviour unchanged.

Verification (CICLOS_ESTABLES=4, ANCHO=3, macro defined unless stated)
REQ-024 SHALL cover: reset 3 cycles, entrada=3'b000 -> all outputs 0 for 20 cycles.
REQ-025 SHALL cover: entrada[0] 0->1 held -> estable[0]=1 exactly 6 edges later, flanco_subida=3'b001 and cambio=1 for that single cycle.
REQ-026 SHALL cover: entrada[1] high for 3 cycles then low (bounce) -> estable stays 3'b000, no flanco pulses.
REQ-027 SHALL cover: entrada 3'b000->3'b110 same edge -> estable=3'b110 after 6 edges, flanco_subida=3'b110, cambio high one cycle; then 3'b110->3'b000 -> flanco_bajada=3'b110 one cycle.
REQ-028 SHALL cover: entrada[2] rises, reset pulsed after 3 edges, entrada held -> no pulse during reset, estable[2]=1 six edges after reset release.
REQ-029 SHALL cover: macro undefined, repeat REQ-025 -> estable identical, flanco_subida/flanco_bajada/cambio constant 0.
